// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fulladder evaluated per clock, LSB first, under a
// three-state IDLE/RUN/DONE controller with registered sum and carry-out.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb, acc, acc_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             last;

  fulladder u_fa (
    .a     (opa[0]),
    .b     (opb[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  // Sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign acc_nx = WIDTH'({fa_sum, acc} >> 1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          carry <= fa_cout;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= acc_nx;
            c_out <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 scenarios plus an exhaustive
// WIDTH=4 sweep against a+b+c_in.

module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       c_in = 1'b0;
  logic       busy, done, c_out;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c_in4 = 1'b0;
  logic       busy4, done4, c_out4;
  logic [3:0] sum4;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c_in4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one WIDTH=8 addition and waits (bounded) for done.
  // lat = edges from acceptance to done; busy_bad counts RUN cycles with busy=0.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       output int lat, output int busy_bad);
    a = va; b = vb; c_in = vc; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    nvec++; if (busy !== 1'b0)  begin nmis++; $display("FAIL reset_busy got=%b exp=0", busy); end
    nvec++; if (done !== 1'b0)  begin nmis++; $display("FAIL reset_done got=%b exp=0", done); end
    nvec++; if (sum !== 8'h00)  begin nmis++; $display("FAIL reset_sum got=%h exp=00", sum); end
    nvec++; if (c_out !== 1'b0) begin nmis++; $display("FAIL reset_cout got=%b exp=0", c_out); end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat, bb;
    do_op(8'h00, 8'h00, 1'b0, lat, bb);
    nvec++; if (lat != 8)       begin nmis++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    nvec++; if (bb != 0)        begin nmis++; $display("FAIL zero_busy_run got=%0d exp=0", bb); end
    nvec++; if (busy !== 1'b0)  begin nmis++; $display("FAIL zero_busy_in_done got=%b exp=0", busy); end
    nvec++; if (sum !== 8'h00)  begin nmis++; $display("FAIL zero_sum got=%h exp=00", sum); end
    nvec++; if (c_out !== 1'b0) begin nmis++; $display("FAIL zero_cout got=%b exp=0", c_out); end
    tick();
    nvec++; if (done !== 1'b0)  begin nmis++; $display("FAIL zero_done_width got=%b exp=0", done); end
  endtask

  task automatic test_overflow();
    int lat, bb;
    do_op(8'hFF, 8'h01, 1'b0, lat, bb);
    nvec++; if ({c_out, sum} !== 9'h100) begin nmis++; $display("FAIL ovf_ff_01 got=%b_%h exp=1_00", c_out, sum); end
    tick();
    do_op(8'hFF, 8'hFF, 1'b1, lat, bb);
    nvec++; if ({c_out, sum} !== 9'h1FF) begin nmis++; $display("FAIL ovf_ff_ff_1 got=%b_%h exp=1_ff", c_out, sum); end
    tick();
    // Result must hold while the next addition is running.
    a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    nvec++; if ({c_out, sum} !== 9'h1FF) begin nmis++; $display("FAIL hold_during_run got=%b_%h exp=1_ff", c_out, sum); end
    for (int i = 0; i < 20 && !done; i++) tick();
    nvec++; if ({c_out, sum} !== 9'h003) begin nmis++; $display("FAIL after_hold got=%b_%h exp=0_03", c_out, sum); end
    tick();
  endtask

  task automatic test_operand_change();
    int lat;
    a = 8'h5A; b = 8'h3C; c_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'h00; b = 8'h00; c_in = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin tick(); lat++; end
    nvec++; if (lat != 8)                begin nmis++; $display("FAIL chg_latency got=%0d exp=8", lat); end
    nvec++; if ({c_out, sum} !== 9'h097) begin nmis++; $display("FAIL chg_result got=%b_%h exp=0_97", c_out, sum); end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx[$];
    logic prev_done = 1'b0;
    int wide = 0, busy_done = 0;
    a = 8'h21; b = 8'h13; c_in = 1'b1; start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done) begin
        if (prev_done) wide++;
        else idx.push_back(i);
        if (busy) busy_done++;
      end
      prev_done = done;
    end
    start = 1'b0;
    nvec++; if (idx.size() != 4) begin nmis++; $display("FAIL b2b_pulses got=%0d exp=4", idx.size()); end
    for (int k = 1; k < idx.size(); k++) begin
      nvec++; if (idx[k] - idx[k-1] != 10) begin nmis++; $display("FAIL b2b_period got=%0d exp=10", idx[k] - idx[k-1]); end
    end
    nvec++; if (wide != 0)      begin nmis++; $display("FAIL b2b_done_width got=%0d exp=0", wide); end
    nvec++; if (busy_done != 0) begin nmis++; $display("FAIL b2b_busy_in_done got=%0d exp=0", busy_done); end
    nvec++; if ({c_out, sum} !== 9'h035) begin nmis++; $display("FAIL b2b_result got=%b_%h exp=0_35", c_out, sum); end
    for (int i = 0; i < 20 && (busy || done); i++) tick();
  endtask

  task automatic test_reset_mid();
    int lat, bb, seen;
    a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++; if (busy !== 1'b0)  begin nmis++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    nvec++; if (sum !== 8'h00)  begin nmis++; $display("FAIL rstmid_sum got=%h exp=00", sum); end
    nvec++; if (c_out !== 1'b0) begin nmis++; $display("FAIL rstmid_cout got=%b exp=0", c_out); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done) seen++; end
    nvec++; if (seen != 0) begin nmis++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
    // Start on the very first edge after reset deasserts.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_op(8'h0F, 8'h01, 1'b0, lat, bb);
    nvec++; if (lat != 8)                begin nmis++; $display("FAIL post_rst_latency got=%0d exp=8", lat); end
    nvec++; if ({c_out, sum} !== 9'h010) begin nmis++; $display("FAIL post_rst_result got=%b_%h exp=0_10", c_out, sum); end
    tick();
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [4:0] exp;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          a4 = 4'(ia); b4 = 4'(ib); c_in4 = 1'(ic); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          lat = 0;
          while (!done4 && lat < 20) begin tick(); lat++; end
          exp = 5'(ia + ib + ic);
          nvec++;
          if (lat != 4 || {c_out4, sum4} !== exp) begin
            nmis++;
            $display("FAIL w4_add a=%h b=%h c=%0d got=%b_%h lat=%0d exp=%b_%h lat=4",
                     ia, ib, ic, c_out4, sum4, lat, exp[4], exp[3:0]);
          end
          tick();
        end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_overflow();
    test_operand_change();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive4();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
